// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and tap-slot helper for the 3x3 convolution scheduler.
package conv_pkg;
  localparam int TAPS    = 9;
  localparam int PIX_W   = 16;
  localparam int ACC_W   = 64;
  localparam int PATCH_W = 144;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Tap 0 (top-left) occupies the most significant slot of PATCH/KERNEL.
  function automatic int tap_msb(input int k);
    return PATCH_W - 1 - PIX_W * k;
  endfunction
endpackage

// File: rtl/conv_addr_gen.sv
// Output-position and tap counters producing the pixel RAM address for each window tap.
// CONV_ZERO_PAD_EN selects a padded (IMG_H x IMG_W) grid with out-of-range tap detection.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              tap_step,
  input  logic              pos_adv,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range,
  output logic              last_pos,
  output logic [15:0]       row,
  output logic [15:0]       col,
  output logic [3:0]        tap
);
`ifdef CONV_ZERO_PAD_EN
  localparam int OUT_W = IMG_W;
  localparam int OUT_H = IMG_H;
`else
  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
`endif
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  logic [15:0] row_r;
  logic [15:0] col_r;
  logic [3:0]  tap_r;
  logic [1:0]  ti_s;
  logic [1:0]  tj_s;
  logic        col_last_s;

  assign col_last_s = (col_r == 16'(OUT_W - 1));
  assign last_pos   = col_last_s && (row_r == 16'(OUT_H - 1));
  assign ti_s       = 2'(tap_r / 4'd3);
  assign tj_s       = 2'(tap_r % 4'd3);
  assign row        = row_r;
  assign col        = col_r;
  assign tap        = tap_r;

  // Tap counter cycles 0..9 through a fetch; position walks the grid row-major.
  always_ff @(posedge CLK) begin
    if (!rst_n || clr) begin
      row_r <= 16'd0;
      col_r <= 16'd0;
      tap_r <= 4'd0;
    end else begin
      if (tap_step) begin
        tap_r <= (tap_r == 4'd9) ? 4'd0 : tap_r + 4'd1;
      end
      if (pos_adv) begin
        if (col_last_s) begin
          col_r <= 16'd0;
          row_r <= row_r + 16'd1;
        end else begin
          col_r <= col_r + 16'd1;
        end
      end
    end
  end

`ifdef CONV_ZERO_PAD_EN
  logic [16:0] row_plus_s;
  logic [16:0] col_plus_s;

  // Pixel coordinate is pos+offset-1; in range when 1 <= pos+offset <= dimension.
  assign row_plus_s = {1'b0, row_r} + {15'd0, ti_s};
  assign col_plus_s = {1'b0, col_r} + {15'd0, tj_s};
  assign in_range   = (tap_r < 4'd9) &&
                      (row_plus_s != 17'd0) && (row_plus_s <= 17'(IMG_H)) &&
                      (col_plus_s != 17'd0) && (col_plus_s <= 17'(IMG_W));
  assign addr = (ADDR_W'(row_r) + ADDR_W'(ti_s) - ADDR_W'(1)) * IMG_W_A
              + ADDR_W'(col_r) + ADDR_W'(tj_s) - ADDR_W'(1);
`else
  assign in_range = (tap_r < 4'd9);
  assign addr = (ADDR_W'(row_r) + ADDR_W'(ti_s)) * IMG_W_A
              + ADDR_W'(col_r) + ADDR_W'(tj_s);
`endif
endmodule

// File: rtl/conv_window_sched.sv
// Sequences the 3x3 convolution datapath: fetches window pixels, holds PATCH, captures RESULT,
// and streams tagged results. Optional padding is selected with CONV_ZERO_PAD_EN.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int ADDR_W   = 16,
  parameter int CONV_LAT = 1
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               kw_en,
  input  logic [3:0]         kw_idx,
  input  logic [PIX_W-1:0]   kw_data,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [PIX_W-1:0]   mem_rd_data,
  output logic [PATCH_W-1:0] PATCH,
  output logic [PATCH_W-1:0] KERNEL,
  input  logic [ACC_W-1:0]   RESULT,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic [15:0]        res_row,
  output logic [15:0]        res_col
);
  localparam int WCNT_W = $clog2(CONV_LAT + 1);

  state_e              state_r, state_s;
  logic                busy_r, done_r, res_valid_r;
  logic [WCNT_W-1:0]   wcnt_r;
  logic                wait_done_s;
  logic                cap_en_r, cap_rd_r;
  logic [3:0]          cap_tap_r;
  logic [PATCH_W-1:0]  patch_r, kernel_r;
  logic [ACC_W-1:0]    res_data_r;
  logic                clr_s, tap_step_s, pos_adv_s;
  logic [ADDR_W-1:0]   ag_addr_s;
  logic                ag_in_range_s, ag_last_s;
  logic [3:0]          ag_tap_s;

  conv_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr_gen (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .tap_step (tap_step_s),
    .pos_adv  (pos_adv_s),
    .addr     (ag_addr_s),
    .in_range (ag_in_range_s),
    .last_pos (ag_last_s),
    .row      (res_row),
    .col      (res_col),
    .tap      (ag_tap_s)
  );

  assign wait_done_s = (wcnt_r == WCNT_W'(CONV_LAT - 1));
  assign mem_rd_en   = (state_r == FETCH) && ag_in_range_s;
  assign mem_rd_addr = mem_rd_en ? ag_addr_s : {ADDR_W{1'b0}};
  assign busy        = busy_r;
  assign done        = done_r;
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;
  assign PATCH       = patch_r;
  assign KERNEL      = kernel_r;

  // Next-state and counter control.
  always_comb begin
    state_s    = state_r;
    clr_s      = 1'b0;
    tap_step_s = 1'b0;
    pos_adv_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = FETCH;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        tap_step_s = 1'b1;
        if (ag_tap_s == 4'd9) state_s = WAIT;
        else                  state_s = FETCH;
      end
      WAIT: begin
        if (wait_done_s) state_s = OUT;
        else             state_s = WAIT;
      end
      OUT: begin
        if (res_ready) begin
          if (ag_last_s) begin
            state_s = FIN;
          end else begin
            state_s   = FETCH;
            pos_adv_s = 1'b1;
          end
        end else begin
          state_s = OUT;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, status flags and the wait-latency counter.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      res_valid_r <= 1'b0;
      wcnt_r      <= {WCNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s == FETCH) || (state_s == WAIT) || (state_s == OUT);
      done_r      <= (state_s == FIN);
      res_valid_r <= (state_s == OUT);
      wcnt_r      <= ((state_r == WAIT) && !wait_done_s) ? wcnt_r + WCNT_W'(1) : {WCNT_W{1'b0}};
    end
  end

  // Read data lands one cycle after the request; skipped (padded) taps capture zero.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      cap_en_r   <= 1'b0;
      cap_rd_r   <= 1'b0;
      cap_tap_r  <= 4'd0;
      patch_r    <= {PATCH_W{1'b0}};
      kernel_r   <= {PATCH_W{1'b0}};
      res_data_r <= {ACC_W{1'b0}};
    end else begin
      cap_en_r  <= (state_r == FETCH) && (ag_tap_s < 4'd9);
      cap_rd_r  <= mem_rd_en;
      cap_tap_r <= ag_tap_s;
      for (int k = 0; k < TAPS; k++) begin
        if (cap_en_r && (cap_tap_r == 4'(k))) begin
          patch_r[tap_msb(k) -: PIX_W] <= cap_rd_r ? mem_rd_data : 16'd0;
        end
        if ((state_r == IDLE) && kw_en && (kw_idx == 4'(k))) begin
          kernel_r[tap_msb(k) -: PIX_W] <= kw_data;
        end
      end
      if ((state_r == WAIT) && wait_done_s) begin
        res_data_r <= RESULT;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched on a 5x5 image (pixel = 5r+c) with a combinational 9-tap MAC.
module tb_conv_window_sched;
  import conv_pkg::*;

  localparam int W = 5;
  localparam int H = 5;
`ifdef CONV_ZERO_PAD_EN
  localparam int OFF = 1;
  localparam int OW  = W;
  localparam int OH  = H;
`else
  localparam int OFF = 0;
  localparam int OW  = W - 2;
  localparam int OH  = H - 2;
`endif

  logic               CLK = 1'b0;
  logic               rst_n, start, kw_en, res_ready;
  logic [3:0]         kw_idx;
  logic [15:0]        kw_data, mem_rd_data;
  logic               busy, done, mem_rd_en, res_valid;
  logic [15:0]        mem_rd_addr, res_row, res_col;
  logic [PATCH_W-1:0] PATCH, KERNEL;
  logic [63:0]        RESULT, res_data;

  typedef struct {
    logic [63:0] data;
    logic [15:0] row;
    logic [15:0] col;
  } res_t;

  res_t res_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  conv_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .CONV_LAT(1)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .kw_en(kw_en), .kw_idx(kw_idx), .kw_data(kw_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .PATCH(PATCH), .KERNEL(KERNEL), .RESULT(RESULT),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col)
  );

  // Pixel RAM: pixel value 5r+c equals its address for this 5-wide image.
  always @(posedge CLK) begin
    if (mem_rd_en) mem_rd_data <= mem_rd_addr;
  end

  always_comb begin
    RESULT = 64'd0;
    for (int k = 0; k < TAPS; k++) begin
      RESULT = RESULT + 64'(PATCH[tap_msb(k) -: 16]) * 64'(KERNEL[tap_msb(k) -: 16]);
    end
  end

  task automatic check_val(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return r * W + c;
  endfunction

  task automatic push_expected();
    res_t e;
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        e.data = 64'd0;
        for (int k = 0; k < TAPS; k++) e.data = e.data + 64'(px(r + k / 3 - OFF, c + k % 3 - OFF));
        e.row = 16'(r);
        e.col = 16'(c);
        res_q.push_back(e);
      end
    end
  endtask

  task automatic load_ones();
    for (int k = 0; k < TAPS; k++) begin
      kw_en = 1'b1; kw_idx = 4'(k); kw_data = 16'd1;
      @(negedge CLK);
    end
    kw_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_rd_en"}, mem_rd_en, 0);
    check_val({tag, "_rd_addr"}, mem_rd_addr, 0);
    check_val({tag, "_valid"}, res_valid, 0);
    check_val({tag, "_patch"}, PATCH, 0);
    check_val({tag, "_kernel"}, KERNEL, 0);
    check_val({tag, "_res_data"}, res_data, 0);
    check_val({tag, "_row"}, res_row, 0);
    check_val({tag, "_col"}, res_col, 0);
  endtask

  task automatic run_frame(input bit first);
    int   cyc = 1, nres = 0, last_hs = -10, stall = 0;
    bit   done_seen = 1'b0, stalled = 1'b0;
    res_t e, snap;
    int   rd_k[$], rd_a[$];
    logic [PATCH_W-1:0] ones, patch_exp;
    push_expected();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    while (!done_seen && cyc < 2000) begin
      if (first) begin
        if (mem_rd_en && cyc <= 9) begin
          rd_k.push_back(cyc - 1);
          rd_a.push_back(int'(mem_rd_addr));
        end
        if (cyc == 11) begin
          patch_exp = '0;
          for (int k = 0; k < TAPS; k++) patch_exp[tap_msb(k) -: 16] = 16'(px(k / 3 - OFF, k % 3 - OFF));
          check_val("first_patch", PATCH, patch_exp);
        end
        if (cyc == 20) begin
          kw_en = 1'b1; kw_idx = 4'd0; kw_data = 16'd55; start = 1'b1;
        end else if (cyc == 21) begin
          kw_en = 1'b0; start = 1'b0;
        end
        if (res_valid && nres == 1 && !stalled) begin
          snap.data = res_data; snap.row = res_row; snap.col = res_col;
          res_ready = 1'b0; stall = 6; stalled = 1'b1;
        end else if (stall > 0) begin
          check_val("stall_valid", res_valid, 1);
          check_val("stall_data", res_data, snap.data);
          check_val("stall_rowcol", {res_row, res_col}, {snap.row, snap.col});
          check_val("stall_no_read", mem_rd_en, 0);
          stall--;
          if (stall == 0) res_ready = 1'b1;
        end
      end
      if (res_valid && res_ready) begin
        check_val("result_expected", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          e = res_q.pop_front();
          check_val("res_data", res_data, e.data);
          check_val("res_row", res_row, e.row);
          check_val("res_col", res_col, e.col);
        end
        nres++;
        last_hs = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        check_val("done_timing", cyc - last_hs, 1);
        check_val("result_count", nres, OH * OW);
        check_val("busy_at_done", busy, 0);
      end
      @(negedge CLK);
      cyc++;
    end
    if (!done_seen) begin
      check_val("frame_timeout", 0, 1);
    end else begin
      check_val("done_single_pulse", done, 0);
      check_val("queue_drained", res_q.size(), 0);
    end
    res_q.delete();
    if (first) begin
      int ek[$], ea[$];
      for (int k = 0; k < TAPS; k++) begin
        if (k / 3 - OFF >= 0 && k % 3 - OFF >= 0) begin
          ek.push_back(k);
          ea.push_back(px(k / 3 - OFF, k % 3 - OFF));
        end
      end
      check_val("first_read_count", rd_k.size(), ek.size());
      for (int i = 0; i < ek.size() && i < rd_k.size(); i++) begin
        check_val("first_read_slot", rd_k[i], ek[i]);
        check_val("first_read_addr", rd_a[i], ea[i]);
      end
      ones = '0;
      for (int k = 0; k < TAPS; k++) ones[tap_msb(k) -: 16] = 16'd1;
      check_val("kernel_locked_busy", KERNEL, ones);
    end
  endtask

  initial begin
    logic [PATCH_W-1:0] kexp;
    int cyc;
    rst_n = 1'b0; start = 1'b0; kw_en = 1'b0; kw_idx = 4'd0; kw_data = 16'd0; res_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge CLK);

    kw_en = 1'b1; kw_idx = 4'd4; kw_data = 16'd7;
    @(negedge CLK);
    kexp = '0;
    kexp[79:64] = 16'd7;
    check_val("kw_idx4", KERNEL, kexp);
    kw_idx = 4'd12; kw_data = 16'd99;
    @(negedge CLK);
    kw_en = 1'b0;
    check_val("kw_idx12_ignored", KERNEL, kexp);

    load_ones();
    run_frame(1'b1);

    // Abort during the third tap fetch, then replay from (0,0).
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge CLK);
    check_all_zero("abort");
    rst_n = 1'b1;
    cyc = 0;
    repeat (5) begin
      @(negedge CLK);
      if (mem_rd_en) cyc++;
    end
    check_val("abort_no_reads", cyc, 0);
    load_ones();
    run_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
